ddr4_cmd_responder: RTL and testbench
=====================================

// Module: ddr4_cmd_responder
// PURPOSE
// Device-side end of the DDR4 command interface: decodes CS/RAS/CAS/WE commands from the controller,
// tracks open rows per bank, stores write data and returns read data after CAS latency. Serves as
// the memory responder in controller-level benches and flags protocol violations for scoreboards.
// PARAMETERS
// ROW_W  4  row bits taken from ddr4_addr[ROW_W-1:0] on ACT
// COL_W  4  column bits taken from ddr4_addr[COL_W-1:0] on RD/WR
// CL     3  read latency in cycles, RD command edge to rd_valid (1..7)
// TRCD   2  min cycles ACT -> RD/WR on the same bank (1..3)
// PORTS
// clk          in   1   system clock, all logic on posedge
// rst_n        in   1   asynchronous active-low reset
// ddr4_cs_n    in   1   chip select, active low
// ddr4_ras_n   in   1   row strobe, active low
// ddr4_cas_n   in   1   column strobe, active low
// ddr4_we_n    in   1   write enable, active low
// ddr4_addr    in   16  row (ACT) / column (RD/WR) / bit 10 = all-banks (PRE)
// ddr4_ba      in   3   bank address
// ddr4_bg      in   2   bank group
// ddr4_dq      in   16  write data, valid in the WR command cycle
// rd_data      out  16  read data
// rd_valid     out  1   one-cycle pulse, rd_data valid
// cmd_err      out  1   one-cycle pulse on illegal command
// err_code     out  3   cause of cmd_err, held until next error
// err_count    out  8   saturating error count (stops at 255)
// open_banks   out  32  bit {bg,ba} = 1 when that bank has an open row
// BEHAVIOUR
// - Reset: all banks closed, TRCD counters 0, read pipe flushed; rd_data=0, rd_valid=0, cmd_err=0,
//   err_code=0, err_count=0, open_banks=0. Storage array is not reset. Reset mid-read drops pending data.
// - Decode (sampled each posedge; cs_n=1 => NOP): {ras,cas,we}_n 111 NOP, 011 ACT, 101 RD, 100 WR,
//   010 PRE; any other encoding (REF/MRS/ZQ) => error code 4, no state change.
// - Bank index b = {ddr4_bg, ddr4_ba} (32 banks). Per bank: open flag, ROW_W-bit row, 2-bit TRCD count.
// - ACT: bank closed -> open, latch row, load TRCD count = TRCD-1 then decrement to 0 each cycle.
//   ACT to an open bank -> error code 2, row unchanged.
// - RD/WR: bank closed -> code 1; bank open with TRCD count != 0 -> code 3. Errored RD gives no
//   rd_valid; errored WR does not commit.
// - WR: mem[{b, open_row, col}] <= ddr4_dq on the WR edge. RD in the following cycle returns new data.
// - RD: storage read at the RD edge, pushed into CL-deep shift pipe; rd_valid high exactly CL cycles
//   after the RD edge. Back-to-back RDs every cycle supported; rd_data holds last value when idle.
// - PRE: addr[10]=1 closes all banks; else closes bank b. PRE to closed bank is legal no-op.
// - Errors: cmd_err pulses 1 cycle after offending command; err_code updated; err_count += 1 (sat).
// - Storage: 2^(5+ROW_W+COL_W) x 16 words (8192 at defaults).
// TESTING
// - Reset then ACT b=5 row 3, 2 idle, WR col 7 dq=0xA5A5, RD col 7 -> rd_valid 3 cycles after RD,
//   rd_data=0xA5A5, no cmd_err.
// - RD b=9 with no ACT -> cmd_err pulse, err_code=1, err_count=1, no rd_valid.
// - ACT b=2 then RD b=2 next cycle -> err_code=3; retry one cycle later -> legal read.
// - ACT b=0 twice -> err_code=2; PRE with addr[10]=1 -> open_banks=0; ACT b=0 again -> no error.
// - Four back-to-back RDs cols 0..3 preloaded 0x1111..0x4444 -> four consecutive rd_valid in order.
// - 300 REF encodings -> err_code=4, err_count saturates at 255; assert rst_n mid-RD -> no rd_valid.

Source files
------------

// File: rtl/ddr4_cmd_responder.sv
// ddr4_cmd_responder
// Device-side model of a DDR4 command interface. Decodes CS/RAS/CAS/WE
// commands, tracks the open row and ACT->RD/WR spacing of all 32 banks,
// stores write data and returns read data CL cycles after the RD edge.
// Illegal commands are reported through a one-cycle cmd_err pulse, a held
// err_code and a saturating err_count.
//
// Ports
//   clk, rst_n                     clock (posedge), async active-low reset
//   ddr4_cs_n/ras_n/cas_n/we_n     command strobes, active low
//   ddr4_addr                      row (ACT), column (RD/WR), bit 10 = all banks (PRE)
//   ddr4_ba, ddr4_bg               bank address / bank group, bank = {bg, ba}
//   ddr4_dq                        write data, sampled on the WR edge
//   rd_data, rd_valid              read return; rd_data holds its last value when idle
//   cmd_err, err_code, err_count   error pulse, last cause, saturating count
//   open_banks                     bit {bg, ba} set while that bank has an open row
module ddr4_cmd_responder #(
    parameter int ROW_W = 4,
    parameter int COL_W = 4,
    parameter int CL    = 3,
    parameter int TRCD  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ddr4_cs_n,
    input  logic        ddr4_ras_n,
    input  logic        ddr4_cas_n,
    input  logic        ddr4_we_n,
    input  logic [15:0] ddr4_addr,
    input  logic [2:0]  ddr4_ba,
    input  logic [1:0]  ddr4_bg,
    input  logic [15:0] ddr4_dq,
    output logic [15:0] rd_data,
    output logic        rd_valid,
    output logic        cmd_err,
    output logic [2:0]  err_code,
    output logic [7:0]  err_count,
    output logic [31:0] open_banks
);

    localparam int NB    = 32;
    localparam int AW    = 5 + ROW_W + COL_W;
    localparam int DEPTH = 1 << AW;
    localparam logic [1:0] TRCD_LD = 2'(TRCD - 1);

    typedef enum logic [2:0] {
        E_NONE    = 3'd0,
        E_CLOSED  = 3'd1,
        E_OPEN    = 3'd2,
        E_TRCD    = 3'd3,
        E_ILLEGAL = 3'd4
    } err_e;

    // Per-bank state
    logic [NB-1:0]    r_open;
    logic [ROW_W-1:0] r_row  [NB];
    logic [1:0]       r_trcd [NB];

    // Storage (not reset)
    logic [15:0]      r_mem [DEPTH];

    // Read pipe: stage 1 is loaded on the RD edge, stage CL drives the outputs
    logic [CL:1]      r_vld_pipe;
    logic [15:0]      r_dat_pipe [1:CL];

    logic             r_cmd_err;
    err_e             r_err_code;
    logic [7:0]       r_err_count;

    logic [4:0]       w_bank;
    logic [2:0]       w_cmd;
    logic             w_act, w_rd, w_wr, w_pre, w_err;
    err_e             w_code;
    logic [AW-1:0]    w_mem_addr;
    logic             w_unused_addr;

    assign w_bank        = {ddr4_bg, ddr4_ba};
    assign w_cmd         = {ddr4_ras_n, ddr4_cas_n, ddr4_we_n};
    assign w_mem_addr    = {w_bank, r_row[w_bank], ddr4_addr[COL_W-1:0]};
    assign w_unused_addr = ^ddr4_addr;

    // Command decode and legality check against current bank state
    always_comb begin
        w_act  = 1'b0;
        w_rd   = 1'b0;
        w_wr   = 1'b0;
        w_pre  = 1'b0;
        w_err  = 1'b0;
        w_code = E_NONE;
        if (!ddr4_cs_n) begin
            case (w_cmd)
                3'b111: ;
                3'b011: begin
                    if (r_open[w_bank]) begin
                        w_err  = 1'b1;
                        w_code = E_OPEN;
                    end else begin
                        w_act = 1'b1;
                    end
                end
                3'b101, 3'b100: begin
                    if (!r_open[w_bank]) begin
                        w_err  = 1'b1;
                        w_code = E_CLOSED;
                    end else if (r_trcd[w_bank] != 2'd0) begin
                        w_err  = 1'b1;
                        w_code = E_TRCD;
                    end else if (w_cmd[0]) begin
                        w_rd = 1'b1;
                    end else begin
                        w_wr = 1'b1;
                    end
                end
                3'b010:  w_pre = 1'b1;
                default: begin
                    w_err  = 1'b1;
                    w_code = E_ILLEGAL;
                end
            endcase
        end
    end

    // Bank open/row/TRCD tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_open <= '0;
            for (int i = 0; i < NB; i++) begin
                r_row[i]  <= '0;
                r_trcd[i] <= 2'd0;
            end
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (r_trcd[i] != 2'd0) r_trcd[i] <= r_trcd[i] - 2'd1;
            end
            if (w_act) begin
                r_open[w_bank] <= 1'b1;
                r_row[w_bank]  <= ddr4_addr[ROW_W-1:0];
                r_trcd[w_bank] <= TRCD_LD;
            end
            if (w_pre) begin
                if (ddr4_addr[10]) r_open         <= '0;
                else               r_open[w_bank] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[w_mem_addr] <= ddr4_dq;
    end

    // Data only advances behind a valid bit so the last stage keeps the
    // most recent read word while the pipe is idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_pipe <= '0;
            for (int i = 1; i <= CL; i++) r_dat_pipe[i] <= 16'h0;
        end else begin
            r_vld_pipe[1] <= w_rd;
            if (w_rd) r_dat_pipe[1] <= r_mem[w_mem_addr];
            for (int i = 2; i <= CL; i++) begin
                r_vld_pipe[i] <= r_vld_pipe[i-1];
                if (r_vld_pipe[i-1]) r_dat_pipe[i] <= r_dat_pipe[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd_err   <= 1'b0;
            r_err_code  <= E_NONE;
            r_err_count <= 8'd0;
        end else begin
            r_cmd_err <= w_err;
            if (w_err) begin
                r_err_code <= w_code;
                if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
            end
        end
    end

    assign rd_valid   = r_vld_pipe[CL];
    assign rd_data    = r_dat_pipe[CL];
    assign cmd_err    = r_cmd_err;
    assign err_code   = r_err_code;
    assign err_count  = r_err_count;
    assign open_banks = r_open;

endmodule

// File: tb/tb_ddr4_cmd_responder.sv
module tb_ddr4_cmd_responder;

    localparam int CL = 3;
    localparam logic [2:0] C_ACT = 3'b011;
    localparam logic [2:0] C_RD  = 3'b101;
    localparam logic [2:0] C_WR  = 3'b100;
    localparam logic [2:0] C_PRE = 3'b010;
    localparam logic [2:0] C_REF = 3'b001;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cs_n, ras_n, cas_n, we_n;
    logic [15:0] addr, dq;
    logic [2:0]  ba;
    logic [1:0]  bg;
    logic [15:0] rd_data;
    logic        rd_valid, cmd_err;
    logic [2:0]  err_code;
    logic [7:0]  err_count;
    logic [31:0] open_banks;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ddr4_cmd_responder #(.ROW_W(4), .COL_W(4), .CL(CL), .TRCD(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .ddr4_cs_n(cs_n), .ddr4_ras_n(ras_n), .ddr4_cas_n(cas_n), .ddr4_we_n(we_n),
        .ddr4_addr(addr), .ddr4_ba(ba), .ddr4_bg(bg), .ddr4_dq(dq),
        .rd_data(rd_data), .rd_valid(rd_valid), .cmd_err(cmd_err),
        .err_code(err_code), .err_count(err_count), .open_banks(open_banks)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic nop;
        cs_n = 1'b1;
        {ras_n, cas_n, we_n} = 3'b111;
    endtask

    // Drive one command for one edge, then return the bus to NOP
    task automatic issue(input logic [2:0] c, input logic [4:0] b,
                         input logic [15:0] a, input logic [15:0] d);
        cs_n = 1'b0;
        {ras_n, cas_n, we_n} = c;
        {bg, ba} = b;
        addr = a;
        dq = d;
        tick();
        nop();
    endtask

    // Called right after the RD edge: valid must appear on the CL-th sample
    task automatic rd_check(input string tag, input logic [15:0] d, input bit cd);
        for (int k = 1; k < CL; k++) begin
            chk({tag, "_early"}, rd_valid, 1'b0);
            tick();
        end
        chk({tag, "_valid"}, rd_valid, 1'b1);
        if (cd) chk({tag, "_data"}, rd_data, d);
        tick();
        chk({tag, "_end"}, rd_valid, 1'b0);
    endtask

    task automatic no_rd(input string tag);
        bit seen;
        seen = 1'b0;
        repeat (CL + 1) begin
            if (rd_valid) seen = 1'b1;
            tick();
        end
        chk(tag, seen, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        nop();
        addr = 16'h0; dq = 16'h0; ba = 3'd0; bg = 2'd0;
        repeat (3) tick();
        rst_n = 1'b1;
        chk("rst_rd_valid", rd_valid, 1'b0);
        chk("rst_rd_data", rd_data, 16'h0);
        chk("rst_cmd_err", cmd_err, 1'b0);
        chk("rst_err_code", err_code, 3'd0);
        chk("rst_err_count", err_count, 8'd0);
        chk("rst_open", open_banks, 32'h0);

        // Basic ACT / WR / RD on bank 5 row 3
        issue(C_ACT, 5'd5, 16'h3, 16'h0);
        chk("t1_open", open_banks, 32'h0000_0020);
        repeat (2) tick();
        issue(C_WR, 5'd5, 16'h7, 16'hA5A5);
        chk("t1_wr_noerr", cmd_err, 1'b0);
        issue(C_RD, 5'd5, 16'h7, 16'h0);
        chk("t1_rd_noerr", cmd_err, 1'b0);
        rd_check("t1", 16'hA5A5, 1'b1);

        // RD to a closed bank
        issue(C_RD, 5'd9, 16'h0, 16'h0);
        chk("t2_cmd_err", cmd_err, 1'b1);
        chk("t2_code", err_code, 3'd1);
        chk("t2_count", err_count, 8'd1);
        no_rd("t2_no_valid");
        chk("t2_pulse_end", cmd_err, 1'b0);

        // TRCD violation, then legal retry
        issue(C_ACT, 5'd2, 16'h1, 16'h0);
        issue(C_RD, 5'd2, 16'h0, 16'h0);
        chk("t3_cmd_err", cmd_err, 1'b1);
        chk("t3_code", err_code, 3'd3);
        chk("t3_count", err_count, 8'd2);
        issue(C_RD, 5'd2, 16'h0, 16'h0);
        chk("t3_retry_noerr", cmd_err, 1'b0);
        rd_check("t3", 16'h0, 1'b0);

        // ACT to open bank, PRE all, re-ACT
        issue(C_ACT, 5'd0, 16'h0, 16'h0);
        issue(C_ACT, 5'd0, 16'h5, 16'h0);
        chk("t4_code", err_code, 3'd2);
        chk("t4_count", err_count, 8'd3);
        chk("t4_open", open_banks, 32'h0000_0025);
        issue(C_PRE, 5'd0, 16'h0400, 16'h0);
        chk("t4_pre_all", open_banks, 32'h0);
        chk("t4_pre_noerr", cmd_err, 1'b0);
        issue(C_ACT, 5'd0, 16'h0, 16'h0);
        chk("t4_reopen_noerr", cmd_err, 1'b0);
        chk("t4_reopen", open_banks, 32'h0000_0001);
        chk("t4_count_hold", err_count, 8'd3);

        // Back-to-back reads of preloaded columns 0..3
        tick();
        issue(C_WR, 5'd0, 16'h0, 16'h1111);
        issue(C_WR, 5'd0, 16'h1, 16'h2222);
        issue(C_WR, 5'd0, 16'h2, 16'h3333);
        issue(C_WR, 5'd0, 16'h3, 16'h4444);
        issue(C_RD, 5'd0, 16'h0, 16'h0);
        chk("t5_c0", rd_valid, 1'b0);
        issue(C_RD, 5'd0, 16'h1, 16'h0);
        chk("t5_c1", rd_valid, 1'b0);
        issue(C_RD, 5'd0, 16'h2, 16'h0);
        chk("t5_v0", rd_valid, 1'b1);
        chk("t5_d0", rd_data, 16'h1111);
        issue(C_RD, 5'd0, 16'h3, 16'h0);
        chk("t5_v1", rd_valid, 1'b1);
        chk("t5_d1", rd_data, 16'h2222);
        tick();
        chk("t5_v2", rd_valid, 1'b1);
        chk("t5_d2", rd_data, 16'h3333);
        tick();
        chk("t5_v3", rd_valid, 1'b1);
        chk("t5_d3", rd_data, 16'h4444);
        tick();
        chk("t5_idle_v", rd_valid, 1'b0);
        chk("t5_idle_hold", rd_data, 16'h4444);

        // Single-bank PRE, PRE to closed bank, errored WR must not commit
        issue(C_PRE, 5'd0, 16'h0, 16'h0);
        chk("t6_pre_one", open_banks, 32'h0);
        issue(C_PRE, 5'd0, 16'h0, 16'h0);
        chk("t6_pre_closed_ok", cmd_err, 1'b0);
        issue(C_WR, 5'd0, 16'h0, 16'hFFFF);
        chk("t6_wr_err", cmd_err, 1'b1);
        chk("t6_wr_code", err_code, 3'd1);
        chk("t6_wr_count", err_count, 8'd4);
        issue(C_ACT, 5'd0, 16'h0, 16'h0);
        tick();
        issue(C_RD, 5'd0, 16'h0, 16'h0);
        rd_check("t6", 16'h1111, 1'b1);

        // Illegal encodings saturate the error counter
        repeat (300) issue(C_REF, 5'd0, 16'h0, 16'h0);
        chk("t7_cmd_err", cmd_err, 1'b1);
        chk("t7_code", err_code, 3'd4);
        chk("t7_count_sat", err_count, 8'd255);
        chk("t7_open_kept", open_banks, 32'h0000_0001);
        tick();
        chk("t7_pulse_end", cmd_err, 1'b0);

        // Reset while a read is in flight
        issue(C_RD, 5'd0, 16'h1, 16'h0);
        #2 rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        no_rd("t8_dropped");
        chk("t8_count", err_count, 8'd0);
        chk("t8_open", open_banks, 32'h0);
        chk("t8_data", rd_data, 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
